// File: rtl/regfile_sized_sb.sv
// Parametrised register file with x86-style byte/word/full sub-register access and a busy scoreboard.
// Optional macro RF_BYPASS_EN enables same-cycle write-to-read forwarding on both read ports.
module regfile_sized_sb #(
    parameter int DATA_W       = 32,
    parameter int NREG         = 8,
    parameter int ADDR_W       = 3,
    parameter int X86_BYTE_MAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_size,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [1:0]        rd1_size,
    input  logic [ADDR_W-1:0] rd2_addr,
    input  logic [1:0]        rd2_size,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd1_ready,
    output logic              rd2_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic [NREG-1:0]   busy_vec
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_FULL = 2'b10;

    // Byte access to indices 4-7 targets bits [15:8] of the register four below.
    function automatic logic byte_hi(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        return (X86_BYTE_MAP != 0) && (s == SZ_BYTE) &&
               ((32'(a) & 32'd4) != 32'd0) && (32'(a) < 32'd8);
    endfunction

    function automatic logic [ADDR_W-1:0] parent_of(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        return byte_hi(a, s) ? a - ADDR_W'(4) : a;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < NREG;
    endfunction

    function automatic logic [DATA_W-1:0] merge_f(input logic [DATA_W-1:0] old,
                                                  input logic [1:0]        s,
                                                  input logic              hi,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = old;
        case (s)
            SZ_BYTE: if (hi) r[15:8] = d[7:0];
                     else    r[7:0]  = d[7:0];
            SZ_WORD: r[15:0] = d[15:0];
            SZ_FULL: r = d;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] extract_f(input logic [DATA_W-1:0] v,
                                                    input logic [1:0]        s,
                                                    input logic              hi);
        logic [DATA_W-1:0] r;
        r = '0;
        case (s)
            SZ_BYTE: r[7:0]  = hi ? v[15:8] : v[7:0];
            SZ_WORD: r[15:0] = v[15:0];
            SZ_FULL: r = v;
            default: ;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0] regs_reg  [NREG];
    logic [DATA_W-1:0] regs_next [NREG];
    logic [NREG-1:0]   busy_reg;
    logic [NREG-1:0]   busy_next;

    logic              wr_hi;
    logic [ADDR_W-1:0] wr_par;
    logic              wr_fire;
    logic              sb_fire;

    assign wr_hi   = byte_hi(wr_addr, wr_size);
    assign wr_par  = parent_of(wr_addr, wr_size);
    assign wr_fire = wr_en && (wr_size != 2'b11) && addr_ok(wr_addr);
    assign sb_fire = sb_set && addr_ok(sb_set_addr);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic hit;
            logic set;
            assign hit            = wr_fire && (wr_par == ADDR_W'(gi));
            assign set            = sb_fire && (sb_set_addr == ADDR_W'(gi));
            assign regs_next[gi]  = hit ? merge_f(regs_reg[gi], wr_size, wr_hi, wr_data) : regs_reg[gi];
            // A new producer issued in the same cycle keeps the register busy.
            assign busy_next[gi]  = set ? 1'b1 : (hit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
            busy_reg <= '0;
        end else begin
            regs_reg <= regs_next;
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    logic [ADDR_W-1:0] rd_addr  [2];
    logic [1:0]        rd_size  [2];
    logic [DATA_W-1:0] rd_data  [2];
    logic              rd_ready [2];

    assign rd_addr[0] = rd1_addr;
    assign rd_addr[1] = rd2_addr;
    assign rd_size[0] = rd1_size;
    assign rd_size[1] = rd2_size;
    assign rd1_data   = rd_data[0];
    assign rd2_data   = rd_data[1];
    assign rd1_ready  = rd_ready[0];
    assign rd2_ready  = rd_ready[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic              hi;
            logic [ADDR_W-1:0] par;
            logic              ok;
            logic [DATA_W-1:0] src;
            logic              rdy;

            assign hi  = byte_hi(rd_addr[gi], rd_size[gi]);
            assign par = parent_of(rd_addr[gi], rd_size[gi]);
            assign ok  = addr_ok(rd_addr[gi]);

            always_comb begin
                src = '0;
                rdy = 1'b1;
                if (ok) begin
                    src = regs_reg[par];
                    rdy = ~busy_reg[par];
`ifdef RF_BYPASS_EN
                    if (wr_fire && (wr_par == par)) begin
                        src = regs_next[par];
                        rdy = ~(sb_fire && (sb_set_addr == par));
                    end
`endif
                end
            end

            assign rd_data[gi]  = extract_f(src, rd_size[gi], hi);
            assign rd_ready[gi] = rdy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sized_sb.sv
// Directed bench for regfile_sized_sb: vector table on the default 8-register build plus a NREG=6 bounds sequence.
module tb_regfile_sized_sb;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, sb_set;
    logic [2:0]  wr_addr, rd1_addr, rd2_addr, sb_set_addr;
    logic [1:0]  wr_size, rd1_size, rd2_size;
    logic [31:0] wr_data, rd1_data, rd2_data;
    logic        rd1_ready, rd2_ready;
    logic [7:0]  busy_vec;

    regfile_sized_sb dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
        .rd1_addr(rd1_addr), .rd1_size(rd1_size), .rd2_addr(rd2_addr), .rd2_size(rd2_size),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_ready(rd1_ready), .rd2_ready(rd2_ready),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec)
    );

    logic        b_rst, b_wr_en, b_sb_set;
    logic [2:0]  b_wr_addr, b_rd1_addr, b_rd2_addr, b_sb_set_addr;
    logic [1:0]  b_wr_size, b_rd1_size, b_rd2_size;
    logic [31:0] b_wr_data, b_rd1_data, b_rd2_data;
    logic        b_rd1_ready, b_rd2_ready;
    logic [5:0]  b_busy_vec;

    regfile_sized_sb #(.NREG(6)) dut6 (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_size(b_wr_size), .wr_data(b_wr_data),
        .rd1_addr(b_rd1_addr), .rd1_size(b_rd1_size), .rd2_addr(b_rd2_addr), .rd2_size(b_rd2_size),
        .rd1_data(b_rd1_data), .rd2_data(b_rd2_data), .rd1_ready(b_rd1_ready), .rd2_ready(b_rd2_ready),
        .sb_set(b_sb_set), .sb_set_addr(b_sb_set_addr), .busy_vec(b_busy_vec)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [1:0]  ws;
        logic [31:0] wd;
        logic        sb;
        logic [2:0]  sa;
        logic [2:0]  r1a;
        logic [1:0]  r1s;
        logic [2:0]  r2a;
        logic [1:0]  r2s;
        logic [31:0] e1;
        logic        y1;
        logic [31:0] e2;
        logic        y2;
        logic [7:0]  eb;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic we, logic [2:0] wa, logic [1:0] ws, logic [31:0] wd,
                                logic sb, logic [2:0] sa,
                                logic [2:0] r1a, logic [1:0] r1s, logic [2:0] r2a, logic [1:0] r2s,
                                logic [31:0] e1, logic y1, logic [31:0] e2, logic y2, logic [7:0] eb);
        vec_t v;
        v.rst = r;  v.we = we;  v.wa = wa;  v.ws = ws;  v.wd = wd;  v.sb = sb;  v.sa = sa;
        v.r1a = r1a; v.r1s = r1s; v.r2a = r2a; v.r2s = r2s;
        v.e1 = e1; v.y1 = y1; v.e2 = e2; v.y2 = y2; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        //                 rst we wa ws     wd            sb sa r1a r1s  r2a r2s   e1            y1 e2            y2 busy
        vecs[0]  = mk(0, 1, 3, 2'b10, 32'hDEADBEEF, 0, 0, 1, 2'b10, 0, 2'b10, 32'h0,        1, 32'h0,        1, 8'h00);
        vecs[1]  = mk(1, 1, 5, 2'b10, 32'h12345678, 1, 5, 3, 2'b10, 0, 2'b10, 32'hDEADBEEF, 1, 32'h0,        1, 8'h00);
        vecs[2]  = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 3, 2'b10, 5, 2'b10, 32'h0,        1, 32'h0,        1, 8'h00);
        vecs[3]  = mk(0, 1, 0, 2'b10, 32'h11223344, 0, 0, 1, 2'b10, 2, 2'b10, 32'h0,        1, 32'h0,        1, 8'h00);
        vecs[4]  = mk(0, 1, 4, 2'b00, 32'h000000AB, 0, 0, 1, 2'b10, 3, 2'b10, 32'h0,        1, 32'h0,        1, 8'h00);
        vecs[5]  = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 0, 2'b10, 4, 2'b00, 32'h1122AB44, 1, 32'h000000AB, 1, 8'h00);
        vecs[6]  = mk(0, 1, 0, 2'b01, 32'h00005566, 0, 0, 1, 2'b10, 2, 2'b10, 32'h0,        1, 32'h0,        1, 8'h00);
        vecs[7]  = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 0, 2'b10, 4, 2'b00, 32'h11225566, 1, 32'h00000055, 1, 8'h00);
        vecs[8]  = mk(0, 0, 0, 2'b10, 32'h0,        1, 2, 2, 2'b10, 0, 2'b01, 32'h0,        1, 32'h00005566, 1, 8'h00);
        vecs[9]  = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 2, 2'b10, 0, 2'b00, 32'h0,        0, 32'h00000066, 1, 8'h04);
        vecs[10] = mk(0, 1, 2, 2'b10, 32'h000000A5, 0, 0, 1, 2'b10, 0, 2'b11, 32'h0,        1, 32'h0,        1, 8'h04);
        vecs[11] = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 2, 2'b10, 6, 2'b00, 32'h000000A5, 1, 32'h0,        1, 8'h00);
        vecs[12] = mk(0, 1, 2, 2'b10, 32'h00000077, 1, 2, 1, 2'b10, 0, 2'b10, 32'h0,        1, 32'h11225566, 1, 8'h00);
        vecs[13] = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 2, 2'b10, 6, 2'b00, 32'h00000077, 0, 32'h0,        0, 8'h04);
        vecs[14] = mk(0, 1, 2, 2'b10, 32'h0000BEEF, 1, 1, 0, 2'b10, 3, 2'b10, 32'h11225566, 1, 32'h0,        1, 8'h04);
        vecs[15] = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 2, 2'b10, 1, 2'b10, 32'h0000BEEF, 1, 32'h0,        0, 8'h02);
        vecs[16] = mk(0, 1, 5, 2'b00, 32'h000000C3, 0, 0, 0, 2'b10, 3, 2'b10, 32'h11225566, 1, 32'h0,        1, 8'h02);
        vecs[17] = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 1, 2'b10, 5, 2'b00, 32'h0000C300, 1, 32'h000000C3, 1, 8'h00);
        vecs[18] = mk(0, 1, 6, 2'b10, 32'h0000FFFF, 0, 0, 1, 2'b10, 0, 2'b10, 32'h0000C300, 1, 32'h11225566, 1, 8'h00);
        vecs[19] = mk(0, 1, 6, 2'b10, 32'hCAFEF00D, 0, 0, 6, 2'b01, 6, 2'b10,
                      BYP ? 32'h0000F00D : 32'h0000FFFF, 1, BYP ? 32'hCAFEF00D : 32'h0000FFFF, 1, 8'h00);
        vecs[20] = mk(0, 1, 6, 2'b10, 32'h00000001, 1, 6, 6, 2'b10, 0, 2'b10,
                      BYP ? 32'h00000001 : 32'hCAFEF00D, !BYP, 32'h11225566, 1, 8'h00);
        vecs[21] = mk(0, 0, 0, 2'b10, 32'h0,        0, 0, 6, 2'b10, 0, 2'b10, 32'h00000001, 0, 32'h11225566, 1, 8'h40);

        rst = 1; wr_en = 0; wr_addr = 0; wr_size = 0; wr_data = 0; sb_set = 0; sb_set_addr = 0;
        rd1_addr = 0; rd1_size = 2'b10; rd2_addr = 0; rd2_size = 2'b10;
        b_rst = 1; b_wr_en = 0; b_wr_addr = 0; b_wr_size = 0; b_wr_data = 0; b_sb_set = 0; b_sb_set_addr = 0;
        b_rd1_addr = 0; b_rd1_size = 2'b10; b_rd2_addr = 0; b_rd2_size = 2'b10;
        repeat (2) @(negedge clk);
        rst = 0;
        b_rst = 0;
        #1;
        chk("reset_busy", 32'(busy_vec), 32'h0);
        chk("reset_rd1", rd1_data, 32'h0);
        chk("reset_b_busy", 32'(b_busy_vec), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_size = vecs[i].ws;
            wr_data = vecs[i].wd; sb_set = vecs[i].sb; sb_set_addr = vecs[i].sa;
            rd1_addr = vecs[i].r1a; rd1_size = vecs[i].r1s; rd2_addr = vecs[i].r2a; rd2_size = vecs[i].r2s;
            #1;
            chk($sformatf("v%0d_rd1_data", i), rd1_data, vecs[i].e1);
            chk($sformatf("v%0d_rd1_ready", i), 32'(rd1_ready), 32'(vecs[i].y1));
            chk($sformatf("v%0d_rd2_data", i), rd2_data, vecs[i].e2);
            chk($sformatf("v%0d_rd2_ready", i), 32'(rd2_ready), 32'(vecs[i].y2));
            chk($sformatf("v%0d_busy_vec", i), 32'(busy_vec), 32'(vecs[i].eb));
            $display("vec %0d: rd1=0x%08h rdy1=%0b rd2=0x%08h rdy2=%0b busy=0x%02h",
                     i, rd1_data, rd1_ready, rd2_data, rd2_ready, busy_vec);
        end
        @(negedge clk);
        wr_en = 0; sb_set = 0;

        // Bounds sequence on the 6-register instance.
        b_wr_en = 1; b_wr_addr = 5; b_wr_size = 2'b10; b_wr_data = 32'h000055AA;
        @(negedge clk);
        b_wr_addr = 7; b_wr_data = 32'hFFFFFFFF; b_sb_set = 1; b_sb_set_addr = 7;
        @(negedge clk);
        b_wr_addr = 6; b_wr_size = 2'b00; b_wr_data = 32'h00000099; b_sb_set_addr = 6;
        @(negedge clk);
        b_wr_en = 0; b_sb_set = 0;
        b_rd1_addr = 7; b_rd1_size = 2'b10; b_rd2_addr = 5; b_rd2_size = 2'b10;
        #1;
        chk("b_rd1_oor_data", b_rd1_data, 32'h0);
        chk("b_rd1_oor_ready", 32'(b_rd1_ready), 32'h1);
        chk("b_rd2_reg5", b_rd2_data, 32'h000055AA);
        chk("b_busy_vec", 32'(b_busy_vec), 32'h0);
        $display("bounds a: rd1=0x%08h rdy1=%0b rd2=0x%08h busy=0x%02h", b_rd1_data, b_rd1_ready, b_rd2_data, b_busy_vec);
        @(negedge clk);
        b_rd1_addr = 2; b_rd1_size = 2'b10; b_rd2_addr = 6; b_rd2_size = 2'b00;
        #1;
        chk("b_rd1_reg2", b_rd1_data, 32'h0);
        chk("b_rd2_oor_byte", b_rd2_data, 32'h0);
        chk("b_rd2_oor_ready", 32'(b_rd2_ready), 32'h1);
        $display("bounds b: rd1=0x%08h rd2=0x%08h rdy2=%0b", b_rd1_data, b_rd2_data, b_rd2_ready);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sized_sb.md
Name: regfile_sized_sb

Overview:
- Parametrised successor to the 8x32 register file used by the agex datapath.
- Adds x86 sub-register addressing (AL/AH/AX/EAX style) on the write port and both read ports, a per-register busy scoreboard for issue/writeback tracking, and synchronous reset.
- Sits between decode (scoreboard set, read select) and writeback (MEM_BUS write) in the datapath.

Parameters:
- DATA_W, 32: register width; must be 16 or greater.
- NREG, 8: number of architectural registers.
- ADDR_W, 3: register index width; must satisfy 2**ADDR_W >= NREG.
- X86_BYTE_MAP, 1:
  - 1: in byte mode, indices 4-7 select bits [15:8] of registers 0-3 (AH, CH, DH, BH).
  - 0: byte mode always selects bits [7:0] of the addressed register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write register index.
- wr_size  in  2  write size: 00 byte, 01 word (16 bits), 10 full DATA_W, 11 reserved (no write).
- wr_data  in  DATA_W  write data; the low bits are used for byte and word writes.
- rd1_addr, rd2_addr  in  ADDR_W  read indices.
- rd1_size, rd2_size  in  2  read sizes, same encoding as wr_size; 11 returns 0.
- rd1_data, rd2_data  out  DATA_W  sized read data, zero-extended.
- rd1_ready, rd2_ready  out  1  source register is not busy.
- sb_set  in  1  mark sb_set_addr busy (instruction issue).
- sb_set_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  NREG  registered scoreboard, bit i = register i busy.

Behaviour:
- Reset: when rst is high at a rising edge, every register becomes 0 and busy_vec becomes 0. All other inputs are ignored that cycle, including wr_en and sb_set. Reset asserted mid-sequence discards pending writes and busy state.
- Write, 1-cycle latency:
  - Byte write replaces 8 bits: bits [15:8] of register (addr-4) when X86_BYTE_MAP=1 and addr[2]=1 and addr<8; otherwise bits [7:0] of register addr.
  - Word write replaces bits [15:0].
  - Full write replaces all DATA_W bits.
  - Unselected bits keep their value.
- Out-of-range index (>= NREG):
  - Writes are dropped.
  - Reads return 0 with ready=1.
  - sb_set is ignored.
- Reads are combinational from the register array, with the same byte/word mapping as writes. The selected field is right-aligned and zero-extended; for example, an AH read returns {0, reg0[15:8]}.
- Scoreboard:
  - A write of any valid size to register r clears busy[r] at the edge; with X86_BYTE_MAP=1, an AH-style write clears the busy bit of the parent register (addr-4).
  - sb_set sets busy[r] at the edge.
  - If a set and a clear hit the same register in the same cycle, set wins (new producer issued).
- rdN_ready = ~busy[parent index of rdN_addr], evaluated on registered busy_vec (subject to bypass below).
- The two read ports are fully independent and may address the same register.

Optional Feature:
- Macro RF_BYPASS_EN.
- When defined, same-cycle write forwarding:
  - If wr_en is high and the write hits the same parent register as a read port, rdN_data reflects the merged post-write value. For example, a byte write of 0xAB to AL while reading EAX = 0x11223344 returns 0x112233AB.
  - rdN_ready is forced to 1 unless sb_set targets that parent register in the same cycle.
- When undefined:
  - Reads return the pre-edge register contents.
  - Ready reflects only registered busy_vec.

Test Plan:
- Reset: write 0xDEADBEEF to reg 3, then assert rst one cycle -> rd1 of reg 3 full reads 0x00000000 and busy_vec=0; a wr_en issued during rst has no effect.
- Sub-register writes:
  - Full write 0x11223344 to reg 0.
  - Byte write 0xAB to addr 4 -> reg 0 reads 0x1122AB44.
  - Word write 0x5566 to reg 0 -> reg 0 reads 0x11225566.
  - Byte read of addr 4 -> 0x00000055.
- Scoreboard:
  - sb_set reg 2 -> next cycle busy_vec=0x04 and rd1_ready=0 for reg 2.
  - Write reg 2 -> busy_vec=0x00 after the edge.
  - Set and write reg 2 in the same cycle -> busy_vec=0x04.
- AH-style clear: set busy on reg 1, then byte write to addr 5 -> busy[1] cleared and reg 1 bits [15:8] updated.
- Bypass, with RF_BYPASS_EN defined:
  - reg 6 = 0x0000FFFF; full write 0xCAFEF00D to reg 6 while rd2 reads reg 6 -> rd2_data=0xCAFEF00D in the same cycle.
  - Same stimulus without the macro -> rd2_data=0x0000FFFF.
- Bounds: with NREG=6, write to index 7 and sb_set index 7 -> no register change, busy_vec unchanged, rd1 of index 7 returns 0 with ready=1.
